// File: rtl/ibex_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ibex_pkg
//  Description : Shared types for the multiply/divide arbiter slice.
//                - md_op_e        : operation requested of the multdiv unit
//                - md_arb_state_e : arbiter FSM state encoding
//  Revision    : 1.0  initial release
// ============================================================================
package ibex_pkg;

    // Multiply/divide operation. MULL/MULH share a leading 0 bit and DIV/REM
    // a leading 1 bit, so bit 1 alone separates multiplier from divider work.
    typedef enum logic [1:0] {
        MD_OP_MULL = 2'b00,
        MD_OP_MULH = 2'b01,
        MD_OP_DIV  = 2'b10,
        MD_OP_REM  = 2'b11
    } md_op_e;

    // Arbiter FSM: IDLE accepts, BUSY waits on the unit, FLUSH drains a kill.
    typedef enum logic [1:0] {
        MdArbIdle  = 2'b00,
        MdArbBusy  = 2'b01,
        MdArbFlush = 2'b10
    } md_arb_state_e;

endpackage : ibex_pkg
`default_nettype wire

// File: rtl/ibex_multdiv_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : ibex_multdiv_arbiter
//  Description : Shares one multdiv unit between two requesters. A request is
//                accepted in IDLE (one-cycle req_ready_o strobe), its operands
//                are latched, and the unit is enabled until md_valid_i returns
//                the result as a one-cycle rsp_valid_o strobe to the owner.
//                The owner may kill its operation; the arbiter then spends one
//                FLUSH cycle returning the unit to idle with no response.
//  Ports       :
//    clk_i, rst_ni               clock, synchronous active-low reset
//    req_valid_i[1:0]            request, held until accepted
//    req_operator_i[1:0]         operation per requester
//    req_signed_mode_i[1:0]      operand signedness per requester
//    req_op_a_i / req_op_b_i     operands per requester
//    req_kill_i[1:0]             abort the owner's in-flight operation
//    req_ready_o[1:0]            accept strobe (IDLE only)
//    rsp_valid_o[1:0]            result strobe to the owner
//    rsp_result_o                result, zero when no response
//    md_*_o                      multdiv unit controls and operands
//    md_valid_i, md_result_i     multdiv unit result handshake
//  Revision    : 1.0  initial release
// ============================================================================
module ibex_multdiv_arbiter
    import ibex_pkg::*;
#(
    parameter bit RoundRobin = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_ni,

    input  logic [1:0]        req_valid_i,
    input  md_op_e [1:0]      req_operator_i,
    input  logic [1:0][1:0]   req_signed_mode_i,
    input  logic [1:0][31:0]  req_op_a_i,
    input  logic [1:0][31:0]  req_op_b_i,
    input  logic [1:0]        req_kill_i,
    output logic [1:0]        req_ready_o,
    output logic [1:0]        rsp_valid_o,
    output logic [31:0]       rsp_result_o,

    output logic              md_mult_en_o,
    output logic              md_div_en_o,
    output logic              md_mult_sel_o,
    output logic              md_div_sel_o,
    output md_op_e            md_operator_o,
    output logic [1:0]        md_signed_mode_o,
    output logic [31:0]       md_op_a_o,
    output logic [31:0]       md_op_b_o,
    output logic              md_ready_id_o,
    input  logic              md_valid_i,
    input  logic [31:0]       md_result_i
);

    // ------------------------------------------------------------------
    // State and captured request
    // ------------------------------------------------------------------
    md_arb_state_e state_q, state_d;
    logic          owner_q;
    md_op_e        op_q;
    logic [1:0]    signed_q;
    logic [31:0]   op_a_q;
    logic [31:0]   op_b_q;
    // Requester that wins the next tie; 0 out of reset.
    logic          prio_q, prio_d;

    // ------------------------------------------------------------------
    // Combinational arbitration and control
    // ------------------------------------------------------------------
    logic [1:0]    w_eligible;
    logic          w_grant_idx;
    logic          w_accept;
    logic          w_busy;
    logic          w_flush;
    logic          w_owner_kill;
    logic          w_mult_op;
    logic          w_rsp_fire;
    logic [1:0]    w_req_ready;
    logic [1:0]    w_rsp_valid;

    // A requester asking to kill in the same cycle is not offered a grant.
    assign w_eligible = req_valid_i & ~req_kill_i;

    always_comb begin
        w_grant_idx = 1'b0;
        if (w_eligible == 2'b11) begin
            w_grant_idx = RoundRobin ? prio_q : 1'b0;
        end else begin
            w_grant_idx = w_eligible[1];
        end
    end

    assign w_busy       = (state_q == MdArbBusy);
    assign w_flush      = (state_q == MdArbFlush);
    assign w_accept     = (state_q == MdArbIdle) && (|w_eligible);
    // Only the owner's kill line matters, and only while BUSY.
    assign w_owner_kill = w_busy && req_kill_i[owner_q];
    assign w_mult_op    = ~op_q[1];
    // A kill in the same cycle as md_valid_i wins: no response is issued.
    assign w_rsp_fire   = w_busy && !w_owner_kill && md_valid_i;

    always_comb begin
        w_req_ready = 2'b00;
        if (w_accept) begin
            w_req_ready[w_grant_idx] = 1'b1;
        end
    end

    always_comb begin
        w_rsp_valid = 2'b00;
        if (w_rsp_fire) begin
            w_rsp_valid[owner_q] = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        unique case (state_q)
            MdArbIdle: begin
                if (w_accept) begin
                    state_d = MdArbBusy;
                    // Pointer moves only on accept: favour the other side.
                    prio_d  = ~w_grant_idx;
                end
            end
            MdArbBusy: begin
                if (w_owner_kill) begin
                    state_d = MdArbFlush;
                end else if (md_valid_i) begin
                    state_d = MdArbIdle;
                end
            end
            MdArbFlush: begin
                state_d = MdArbIdle;
            end
            default: begin
                state_d = MdArbIdle;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= MdArbIdle;
            owner_q  <= 1'b0;
            op_q     <= MD_OP_MULL;
            signed_q <= 2'b00;
            op_a_q   <= 32'd0;
            op_b_q   <= 32'd0;
            prio_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            if (w_accept) begin
                owner_q  <= w_grant_idx;
                op_q     <= req_operator_i[w_grant_idx];
                signed_q <= req_signed_mode_i[w_grant_idx];
                op_a_q   <= req_op_a_i[w_grant_idx];
                op_b_q   <= req_op_b_i[w_grant_idx];
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs. Everything is forced to its idle value while rst_ni is low
    // so nothing leaks out combinationally from live request inputs.
    // ------------------------------------------------------------------
    assign req_ready_o      = rst_ni ? w_req_ready : 2'b00;
    assign rsp_valid_o      = rst_ni ? w_rsp_valid : 2'b00;
    assign rsp_result_o     = (rst_ni && w_rsp_fire) ? md_result_i : 32'd0;

    // Enables drop in the kill cycle; selects stay up until FLUSH.
    assign md_mult_en_o     = rst_ni && w_busy && w_mult_op && !w_owner_kill;
    assign md_div_en_o      = rst_ni && w_busy && !w_mult_op && !w_owner_kill;
    assign md_mult_sel_o    = rst_ni && w_busy && w_mult_op;
    assign md_div_sel_o     = rst_ni && w_busy && !w_mult_op;

    assign md_operator_o    = rst_ni ? op_q : MD_OP_MULL;
    assign md_signed_mode_o = rst_ni ? signed_q : 2'b00;
    assign md_op_a_o        = rst_ni ? op_a_q : 32'd0;
    assign md_op_b_o        = rst_ni ? op_b_q : 32'd0;

    // The unit also needs the consume strobe in FLUSH to drop its partial op.
    assign md_ready_id_o    = rst_ni && (w_rsp_fire || w_flush);

endmodule : ibex_multdiv_arbiter
`default_nettype wire
